// File: rtl/enc_pkg.sv
// Shared sizing and types for the one-hot decoder stage and its event counter.
package enc_pkg;

    localparam int unsigned N_LINES = 15;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned CNT_W   = 8;

    typedef logic [N_LINES-1:0] onehot_t;
    typedef logic [IDX_W-1:0]   idx_t;
    typedef logic [CNT_W-1:0]   cnt_t;

endpackage

// File: rtl/onehot_sat_counter.sv
// One saturating event counter with a sticky overflow flag.
// Priority: clr > (inc with rd_clr_sel -> 1) > inc > rd_clr_sel.
module onehot_sat_counter #(
    parameter int unsigned CNT_W = enc_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             rd_clr_sel,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc && rd_clr_sel) begin
            // The read returned the old value, so only this edge's event remains.
            cnt <= CNT_W'(1);
        end else if (inc) begin
            if (cnt == CNT_MAX) begin
                ovf <= 1'b1;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else if (rd_clr_sel) begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/onehot_event_counter.sv
// Per-line event histogram behind the one-hot decoder: input register,
// multi-hot check, saturating counters and a registered read port.
module onehot_event_counter #(
    parameter int unsigned N_LINES = enc_pkg::N_LINES,
    parameter int unsigned IDX_W   = enc_pkg::IDX_W,
    parameter int unsigned CNT_W   = enc_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic [N_LINES-1:0] onehot_in,
    input  logic               rd_en,
    input  logic [IDX_W-1:0]   rd_idx,
    input  logic               rd_clr,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_valid,
    output logic [N_LINES-1:0] ovf,
    output logic               err_multi
);

    logic [N_LINES-1:0] ev_q;
    logic [N_LINES-1:0] inc_c;
    logic [N_LINES-1:0] rd_clr_sel_c;
    logic [CNT_W-1:0]   cnt_q [N_LINES];
    logic [CNT_W-1:0]   rd_mux_c;
    logic               multi_c;

    // Stage 1: capture the decoder output; clr drops any in-flight event.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_q <= '0;
        end else if (clr) begin
            ev_q <= '0;
        end else begin
            ev_q <= onehot_in;
        end
    end

    // Two or more bits set iff clearing the lowest set bit leaves something.
    assign multi_c = |(ev_q & (ev_q - N_LINES'(1)));

    always_comb begin
        inc_c        = '0;
        rd_clr_sel_c = '0;
        rd_mux_c     = '0;
        if (!multi_c) begin
            inc_c = ev_q;
        end
        for (int i = 0; i < int'(N_LINES); i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_clr_sel_c[i] = rd_en & rd_clr;
                rd_mux_c        = cnt_q[i];
            end
        end
    end

    for (genvar g = 0; g < int'(N_LINES); g++) begin : g_cnt
        onehot_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk        (clk),
            .rst        (rst),
            .clr        (clr),
            .inc        (inc_c[g]),
            .rd_clr_sel (rd_clr_sel_c[g]),
            .cnt        (cnt_q[g]),
            .ovf        (ovf[g])
        );
    end

    // Clear wins over a multi-hot detection at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_multi <= 1'b0;
        end else if (clr) begin
            err_multi <= 1'b0;
        end else if (multi_c) begin
            err_multi <= 1'b1;
        end
    end

    // Read register samples pre-update counter values; out-of-range reads give 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_mux_c;
            end
        end
    end

endmodule

// File: tb/tb_onehot_event_counter.sv
// Directed self-checking bench for onehot_event_counter.
`timescale 1ns/1ps
module tb_onehot_event_counter;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [14:0] onehot_in;
    logic        rd_en;
    logic [3:0]  rd_idx;
    logic        rd_clr;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [14:0] ovf;
    logic        err_multi;

    int checks = 0;
    int errors = 0;

    onehot_event_counter dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .onehot_in (onehot_in),
        .rd_en     (rd_en),
        .rd_idx    (rd_idx),
        .rd_clr    (rd_clr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ovf       (ovf),
        .err_multi (err_multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [3:0] idx, input logic clr_sel,
                           output logic [7:0] d, output logic v);
        rd_en  = 1'b1;
        rd_idx = idx;
        rd_clr = clr_sel;
        tick();
        d = rd_data;
        v = rd_valid;
        rd_en  = 1'b0;
        rd_clr = 1'b0;
    endtask

    task automatic events(input logic [14:0] v, input int n);
        onehot_in = v;
        repeat (n) tick();
        onehot_in = '0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        logic [7:0] d;
        logic       v;
        rst = 1'b0; clr = 1'b0; onehot_in = '0;
        rd_en = 1'b0; rd_idx = '0; rd_clr = 1'b0;
        repeat (2) tick();
        checks++;
        if (rd_data !== 8'd0 || rd_valid !== 1'b0 || ovf !== 15'h0 || err_multi !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%0d valid=%b ovf=%h err=%b exp 0/0/0/0",
                     rd_data, rd_valid, ovf, err_multi);
        end
        @(negedge clk) rst = 1'b1;
        tick();
        do_read(4'd0, 1'b0, d, v);
        checks++;
        if (d !== 8'd0 || v !== 1'b1) begin
            errors++;
            $display("FAIL reset_read0: got data=%0d valid=%b exp 0/1", d, v);
        end
    endtask

    task automatic test_single_events();
        logic [7:0] d;
        logic       v;
        onehot_in = 15'h0001;
        repeat (3) tick();
        onehot_in = 15'h4000;
        tick();
        onehot_in = '0;
        repeat (2) tick();
        do_read(4'd0, 1'b0, d, v);
        checks++;
        if (d !== 8'd3 || v !== 1'b1) begin
            errors++;
            $display("FAIL single_idx0: got data=%0d valid=%b exp 3/1", d, v);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 8'd3) begin
            errors++;
            $display("FAIL valid_pulse: got valid=%b data=%0d exp 0/3", rd_valid, rd_data);
        end
        do_read(4'd14, 1'b0, d, v);
        checks++;
        if (d !== 8'd1 || v !== 1'b1) begin
            errors++;
            $display("FAIL single_idx14: got data=%0d valid=%b exp 1/1", d, v);
        end
        do_read(4'd3, 1'b0, d, v);
        checks++;
        if (d !== 8'd0) begin
            errors++;
            $display("FAIL single_idx3: got %0d exp 0", d);
        end
        do_read(4'd13, 1'b0, d, v);
        checks++;
        if (d !== 8'd0) begin
            errors++;
            $display("FAIL single_idx13: got %0d exp 0", d);
        end
    endtask

    task automatic test_multi_hot();
        logic [7:0] d;
        logic       v;
        onehot_in = 15'h0011;
        tick();
        onehot_in = '0;
        tick();
        checks++;
        if (err_multi !== 1'b1) begin
            errors++;
            $display("FAIL multi_err: got %b exp 1", err_multi);
        end
        tick();
        do_read(4'd0, 1'b0, d, v);
        checks++;
        if (d !== 8'd3) begin
            errors++;
            $display("FAIL multi_idx0: got %0d exp 3", d);
        end
        do_read(4'd4, 1'b0, d, v);
        checks++;
        if (d !== 8'd0) begin
            errors++;
            $display("FAIL multi_idx4: got %0d exp 0", d);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        checks++;
        if (err_multi !== 1'b0) begin
            errors++;
            $display("FAIL multi_clr_err: got %b exp 0", err_multi);
        end
        do_read(4'd0, 1'b0, d, v);
        checks++;
        if (d !== 8'd0) begin
            errors++;
            $display("FAIL multi_clr_idx0: got %0d exp 0", d);
        end
    endtask

    task automatic test_saturation();
        logic [7:0] d;
        logic       v;
        events(15'h0020, 254);
        checks++;
        if (ovf !== 15'h0000) begin
            errors++;
            $display("FAIL sat_no_ovf_early: got %h exp 0000", ovf);
        end
        events(15'h0020, 6);
        checks++;
        if (ovf !== 15'h0020) begin
            errors++;
            $display("FAIL sat_ovf: got %h exp 0020", ovf);
        end
        do_read(4'd5, 1'b1, d, v);
        checks++;
        if (d !== 8'd255) begin
            errors++;
            $display("FAIL sat_read: got %0d exp 255", d);
        end
        do_read(4'd5, 1'b0, d, v);
        checks++;
        if (d !== 8'd0) begin
            errors++;
            $display("FAIL sat_after_rdclr: got %0d exp 0", d);
        end
        checks++;
        if (ovf !== 15'h0020) begin
            errors++;
            $display("FAIL sat_ovf_sticky: got %h exp 0020", ovf);
        end
    endtask

    task automatic test_clear_on_read_collision();
        logic [7:0] d;
        logic       v;
        events(15'h0080, 4);
        onehot_in = 15'h0080;
        tick();
        onehot_in = '0;
        do_read(4'd7, 1'b1, d, v);
        checks++;
        if (d !== 8'd4) begin
            errors++;
            $display("FAIL collide_read: got %0d exp 4", d);
        end
        do_read(4'd7, 1'b0, d, v);
        checks++;
        if (d !== 8'd1) begin
            errors++;
            $display("FAIL collide_after: got %0d exp 1", d);
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] d;
        logic       v;
        onehot_in = 15'h0003;
        tick();
        onehot_in = 15'h0004;
        tick();
        rd_en = 1'b1; rd_idx = 4'd7;
        tick();
        checks++;
        if (rd_data !== 8'd1 || rd_valid !== 1'b1 || err_multi !== 1'b1 || ovf !== 15'h0020) begin
            errors++;
            $display("FAIL areset_pre: got data=%0d valid=%b err=%b ovf=%h exp 1/1/1/0020",
                     rd_data, rd_valid, err_multi, ovf);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rd_data !== 8'd0 || rd_valid !== 1'b0 || ovf !== 15'h0 || err_multi !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: got data=%0d valid=%b ovf=%h err=%b exp 0/0/0/0",
                     rd_data, rd_valid, ovf, err_multi);
        end
        rd_en = 1'b0;
        onehot_in = '0;
        tick();
        @(negedge clk) rst = 1'b1;
        repeat (2) tick();
        do_read(4'd2, 1'b0, d, v);
        checks++;
        if (d !== 8'd0 || v !== 1'b1) begin
            errors++;
            $display("FAIL areset_idx2: got data=%0d valid=%b exp 0/1", d, v);
        end
    endtask

    task automatic test_out_of_range_and_clr();
        logic [7:0] d;
        logic       v;
        events(15'h0002, 2);
        do_read(4'd1, 1'b0, d, v);
        checks++;
        if (d !== 8'd2) begin
            errors++;
            $display("FAIL oor_pre_idx1: got %0d exp 2", d);
        end
        do_read(4'd15, 1'b1, d, v);
        checks++;
        if (d !== 8'd0 || v !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got data=%0d valid=%b exp 0/1", d, v);
        end
        onehot_in = 15'h0008;
        tick();
        onehot_in = '0;
        clr = 1'b1;
        do_read(4'd1, 1'b0, d, v);
        clr = 1'b0;
        checks++;
        if (d !== 8'd2) begin
            errors++;
            $display("FAIL clr_preclear_read: got %0d exp 2", d);
        end
        repeat (2) tick();
        do_read(4'd3, 1'b0, d, v);
        checks++;
        if (d !== 8'd0) begin
            errors++;
            $display("FAIL clr_drops_event: got %0d exp 0", d);
        end
        do_read(4'd1, 1'b0, d, v);
        checks++;
        if (d !== 8'd0) begin
            errors++;
            $display("FAIL clr_idx1: got %0d exp 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_single_events();
        test_multi_hot();
        test_saturation();
        test_clear_on_read_collision();
        test_async_reset();
        test_out_of_range_and_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
